// File: rtl/ysyx_22040931_redirect_ctrl_pkg.sv
// Shared defines for the redirect controller: FSM encoding, default widths,
// and the opcode/ALU constants the decode path shares with this block.
package ysyx_22040931_redirect_ctrl_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } rd_state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // After loading a new target, wait out an in-flight fetch before redirecting.
    function automatic rd_state_e load_state(input logic busy);
        if (busy) begin
            return ST_DRAIN;
        end else begin
            return ST_REDIRECT;
        end
    endfunction

endpackage

// File: rtl/ysyx_22040931_redirect_ctrl_jtarget.sv
// Jump target adder and alignment check (combinational).
module ysyx_22040931_jtarget
    import ysyx_22040931_redirect_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            jalr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    logic [XLEN-1:0] sum_s;

    // jalr is register-relative with bit 0 forced low; jal is pc-relative.
    always_comb begin
        if (jalr) begin
            sum_s  = rs1 + imm;
            target = {sum_s[XLEN-1:1], 1'b0};
        end else begin
            sum_s  = pc + imm;
            target = sum_s;
        end
        misalign = target[1];
    end

endmodule

// File: rtl/ysyx_22040931_redirect_ctrl.sv
// Jump/trap redirect controller: accepts decoded jumps and traps, drains an
// outstanding fetch, then hands the new pc to the fetch unit.
module ysyx_22040931_redirect_ctrl
    import ysyx_22040931_redirect_ctrl_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_jump,
    input  logic             id_jalr,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [XLEN-1:0]  id_rs1,
    input  logic             exc_valid,
    input  logic [XLEN-1:0]  exc_pc,
    input  logic             if_busy,
    input  logic             redirect_ready,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_if,
    output logic             flush_id,
    output logic             stall_id,
    output logic             link_valid,
    output logic [XLEN-1:0]  link_data,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [XLEN-1:0]  LINK_OFS = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rd_state_e       state_r;
    rd_state_e       next_state_s;
    logic [XLEN-1:0] target_r;
    logic [XLEN-1:0] target_s;
    logic            misalign_s;
    logic            jump_req_s;
    logic            take_jump_s;
    logic            bad_jump_s;
    logic            handshake_s;
    logic            cnt_max_s;

    ysyx_22040931_jtarget #(
        .XLEN (XLEN)
    ) u_jtarget (
        .jalr     (id_jalr),
        .pc       (id_pc),
        .imm      (id_imm),
        .rs1      (id_rs1),
        .target   (target_s),
        .misalign (misalign_s)
    );

    assign jump_req_s  = id_valid & id_jump;
    assign handshake_s = redirect_valid & redirect_ready;
    assign cnt_max_s   = &redirect_cnt;
    assign redirect_pc = target_r;

    // Next-state selection; a trap overrides whatever the FSM was doing.
    always_comb begin
        next_state_s = ST_IDLE;
        take_jump_s  = 1'b0;
        bad_jump_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (exc_valid) begin
                    next_state_s = load_state(if_busy);
                end else if (jump_req_s) begin
                    if (misalign_s) begin
                        bad_jump_s   = 1'b1;
                        next_state_s = ST_IDLE;
                    end else begin
                        take_jump_s  = 1'b1;
                        next_state_s = load_state(if_busy);
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (exc_valid) begin
                    next_state_s = load_state(if_busy);
                end else if (!if_busy) begin
                    next_state_s = ST_REDIRECT;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_REDIRECT: begin
                if (exc_valid) begin
                    next_state_s = load_state(if_busy);
                end else if (handshake_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_REDIRECT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, target and all pipeline-control outputs are registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            target_r       <= '0;
            redirect_valid <= 1'b0;
            flush_if       <= 1'b0;
            flush_id       <= 1'b0;
            stall_id       <= 1'b0;
            link_valid     <= 1'b0;
            link_data      <= '0;
            misalign_err   <= 1'b0;
            redirect_cnt   <= '0;
        end else begin
            state_r        <= next_state_s;
            redirect_valid <= (next_state_s == ST_REDIRECT);
            flush_if       <= (next_state_s == ST_DRAIN);
            stall_id       <= (next_state_s != ST_IDLE);
            flush_id       <= handshake_s;
            link_valid     <= take_jump_s;
            misalign_err   <= bad_jump_s;

            if (exc_valid) begin
                target_r <= exc_pc;
            end else if (take_jump_s) begin
                target_r <= target_s;
            end else begin
                target_r <= target_r;
            end

            if (take_jump_s) begin
                link_data <= id_pc + LINK_OFS;
            end else begin
                link_data <= link_data;
            end

            // A completed handshake still counts when a trap arrives alongside it.
            if (handshake_s && !cnt_max_s) begin
                redirect_cnt <= redirect_cnt + CNT_ONE;
            end else begin
                redirect_cnt <= redirect_cnt;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040931_redirect_ctrl.sv
// Self-checking bench for ysyx_22040931_redirect_ctrl: directed vector table,
// randomized jumps against a transaction-level model, and trap/reset sequences.
module tb_ysyx_22040931_redirect_ctrl;

    localparam int XLEN    = 64;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, id_jump, id_jalr;
    logic [XLEN-1:0]  id_pc, id_imm, id_rs1;
    logic             exc_valid;
    logic [XLEN-1:0]  exc_pc;
    logic             if_busy, redirect_ready;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush_if, flush_id, stall_id;
    logic             link_valid;
    logic [XLEN-1:0]  link_data;
    logic             misalign_err;
    logic [CNT_W-1:0] redirect_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int model_cnt = 0;

    ysyx_22040931_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_jump(id_jump), .id_jalr(id_jalr),
        .id_pc(id_pc), .id_imm(id_imm), .id_rs1(id_rs1),
        .exc_valid(exc_valid), .exc_pc(exc_pc),
        .if_busy(if_busy), .redirect_ready(redirect_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_if(flush_if), .flush_id(flush_id), .stall_id(stall_id),
        .link_valid(link_valid), .link_data(link_data),
        .misalign_err(misalign_err), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] ref_target(input bit jalr, input logic [63:0] pc,
                                               input logic [63:0] imm, input logic [63:0] rs1);
        logic [63:0] t;
        if (jalr) begin
            t = rs1 + imm;
            t = t - (t % 64'd2);
        end else begin
            t = pc + imm;
        end
        return t;
    endfunction

    task automatic count_redirect();
        if (model_cnt < CNT_MAX) model_cnt++;
    endtask

    // One complete jump transaction, starting and ending at a negedge in IDLE.
    task automatic do_jump(input bit jalr, input logic [63:0] pc, input logic [63:0] imm,
                           input logic [63:0] rs1, input int busy_n, input int rdy_dly,
                           input logic [63:0] exp_t);
        bit mis;
        int busy_left;
        int drain;
        mis = ((exp_t / 64'd2) % 64'd2) == 64'd1;
        id_valid = 1'b1; id_jump = 1'b1; id_jalr = jalr;
        id_pc = pc; id_imm = imm; id_rs1 = rs1;
        if_busy = (busy_n > 0); redirect_ready = 1'b0;
        step();
        id_valid = 1'b0; id_jump = 1'b0;
        chk("flush_id_clear", flush_id, 64'd0);
        chk("misalign_err", misalign_err, mis);
        chk("link_valid", link_valid, !mis);
        if (mis) begin
            if_busy = 1'b0;
            chk("mis_no_redirect", redirect_valid, 64'd0);
            chk("mis_stall", stall_id, 64'd0);
            chk("mis_cnt", redirect_cnt, model_cnt);
            step();
            chk("mis_pulse_end", misalign_err, 64'd0);
            chk("mis_no_redirect2", redirect_valid, 64'd0);
            return;
        end
        chk("link_data", link_data, pc + 64'd4);
        busy_left = busy_n - 1;
        drain = 0;
        while (!redirect_valid && drain < 50) begin
            chk("drain_flush_if", flush_if, 64'd1);
            chk("drain_stall", stall_id, 64'd1);
            drain++;
            if_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            step();
        end
        chk("drain_cycles", drain, busy_n);
        if_busy = 1'b0;
        for (int i = 0; i <= rdy_dly; i++) begin
            chk("redirect_valid", redirect_valid, 64'd1);
            chk("redirect_pc", redirect_pc, exp_t);
            chk("redir_flush_if", flush_if, 64'd0);
            chk("redir_stall", stall_id, 64'd1);
            redirect_ready = (i == rdy_dly);
            step();
        end
        redirect_ready = 1'b0;
        count_redirect();
        chk("done_valid", redirect_valid, 64'd0);
        chk("done_flush_id", flush_id, 64'd1);
        chk("done_stall", stall_id, 64'd0);
        chk("done_cnt", redirect_cnt, model_cnt);
    endtask

    typedef struct {
        bit          jalr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] rs1;
        int          busy_n;
        int          rdy_dly;
        logic [63:0] exp_t;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b0, 64'h8000_0000, 64'h10, 64'h0, 0, 0, 64'h8000_0010};
        tbl[1] = '{1'b1, 64'h8000_0020, 64'h3, 64'h8000_0101, 0, 1, 64'h8000_0104};
        tbl[2] = '{1'b0, 64'h8000_0000, 64'h2, 64'h0, 0, 0, 64'h8000_0002};
        tbl[3] = '{1'b0, 64'h8000_1000, 64'h40, 64'h0, 3, 2, 64'h8000_1040};
        tbl[4] = '{1'b0, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 1, 0, 64'h8000_0000};
        tbl[5] = '{1'b1, 64'h0, 64'h8, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h4};
        tbl[6] = '{1'b1, 64'h0, 64'h1, 64'h1001, 2, 0, 64'h1002};
        tbl[7] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 64'h0, 2, 1, 64'h8};

        rst = 1'b1;
        id_valid = 1'b0; id_jump = 1'b0; id_jalr = 1'b0;
        id_pc = '0; id_imm = '0; id_rs1 = '0;
        exc_valid = 1'b0; exc_pc = '0; if_busy = 1'b0; redirect_ready = 1'b0;
        step(); step();
        chk("rst_redirect_valid", redirect_valid, 64'd0);
        chk("rst_stall", stall_id, 64'd0);
        chk("rst_cnt", redirect_cnt, 64'd0);
        chk("rst_link_data", link_data, 64'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            do_jump(tbl[i].jalr, tbl[i].pc, tbl[i].imm, tbl[i].rs1,
                    tbl[i].busy_n, tbl[i].rdy_dly, tbl[i].exp_t);
        end

        // Trap arriving while a jump is draining replaces its target.
        id_valid = 1'b1; id_jump = 1'b1; id_jalr = 1'b0;
        id_pc = 64'h8000_2000; id_imm = 64'h100; if_busy = 1'b1;
        step();
        id_valid = 1'b0; id_jump = 1'b0;
        chk("exc_drain_link", link_valid, 64'd1);
        exc_valid = 1'b1; exc_pc = 64'h8000_0800;
        step();
        exc_valid = 1'b0;
        chk("exc_drain_flush_if", flush_if, 64'd1);
        chk("exc_drain_nolink", link_valid, 64'd0);
        chk("exc_drain_novalid", redirect_valid, 64'd0);
        if_busy = 1'b0;
        step();
        chk("exc_redirect_pc", redirect_pc, 64'h8000_0800);
        chk("exc_redirect_valid", redirect_valid, 64'd1);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        count_redirect();
        chk("exc_cnt", redirect_cnt, model_cnt);
        step();
        chk("exc_single_redirect", redirect_valid, 64'd0);

        // Trap and misaligned jump in the same IDLE cycle: trap wins.
        id_valid = 1'b1; id_jump = 1'b1; id_jalr = 1'b0;
        id_pc = 64'h8000_0000; id_imm = 64'h2;
        exc_valid = 1'b1; exc_pc = 64'h8000_0900;
        step();
        id_valid = 1'b0; id_jump = 1'b0; exc_valid = 1'b0;
        chk("coinc_nolink", link_valid, 64'd0);
        chk("coinc_nomis", misalign_err, 64'd0);
        chk("coinc_valid", redirect_valid, 64'd1);
        chk("coinc_pc", redirect_pc, 64'h8000_0900);

        // Trap coincident with handshake: completed redirect counts, trap follows.
        redirect_ready = 1'b1; exc_valid = 1'b1; exc_pc = 64'h8000_0A00;
        step();
        redirect_ready = 1'b0; exc_valid = 1'b0;
        count_redirect();
        chk("hs_exc_flush_id", flush_id, 64'd1);
        chk("hs_exc_cnt", redirect_cnt, model_cnt);
        chk("hs_exc_valid", redirect_valid, 64'd1);
        chk("hs_exc_pc", redirect_pc, 64'h8000_0A00);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        count_redirect();
        chk("hs_exc_cnt2", redirect_cnt, model_cnt);
        chk("hs_exc_done", redirect_valid, 64'd0);
        step();

        for (int i = 0; i < 40; i++) begin
            bit          jalr;
            logic [63:0] pc, imm, rs1;
            logic [31:0] r;
            jalr = bit'($urandom_range(0, 1));
            pc   = {$urandom, $urandom} & ~64'h3;
            r    = $urandom;
            imm  = {{52{r[11]}}, r[11:0]};
            rs1  = {$urandom, $urandom};
            do_jump(jalr, pc, imm, rs1, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), ref_target(jalr, pc, imm, rs1));
        end

        for (int i = 0; i < 16; i++) begin
            do_jump(1'b0, 64'h8000_0000, 64'h20, 64'h0, 0, 0, 64'h8000_0020);
        end
        chk("cnt_saturated", redirect_cnt, 64'hF);

        // Reset mid-REDIRECT aborts immediately with no trailing pulse.
        id_valid = 1'b1; id_jump = 1'b1; id_jalr = 1'b0;
        id_pc = 64'h8000_3000; id_imm = 64'h8; if_busy = 1'b0;
        step();
        id_valid = 1'b0; id_jump = 1'b0;
        chk("pre_rst_valid", redirect_valid, 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", redirect_valid, 64'd0);
        chk("rst_mid_pc", redirect_pc, 64'd0);
        chk("rst_mid_stall", stall_id, 64'd0);
        chk("rst_mid_link", link_valid, 64'd0);
        chk("rst_mid_link_data", link_data, 64'd0);
        chk("rst_mid_cnt", redirect_cnt, 64'd0);
        model_cnt = 0;
        step();
        rst = 1'b0;
        redirect_ready = 1'b1;
        step();
        chk("post_rst_valid", redirect_valid, 64'd0);
        chk("post_rst_flush_id", flush_id, 64'd0);
        step();
        chk("post_rst_flush_id2", flush_id, 64'd0);
        chk("post_rst_cnt", redirect_cnt, 64'd0);
        redirect_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
